// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: default line width, word/line typedefs, cache FSM
// states and a width helper for deriving index/offset field sizes.
package lc3b_types;

    localparam int LC3B_LINE_BITS = 128;

    typedef logic [15:0]               lc3b_word;
    typedef logic [LC3B_LINE_BITS-1:0] lc3b_line;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FLUSH
    } icache_state_e;

    // Bit width needed to index n items; a single item still needs one bit.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: applies an access to a way and reports the
// way the tree currently points at for eviction. Purely combinational.
module plru_tree
    import lc3b_types::*;
#(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]           plru_bits,
    input  logic [width_of(WAYS)-1:0] access_way,
    output logic [WAYS-2:0]           plru_next,
    output logic [width_of(WAYS)-1:0] victim_way
);

    localparam int WW = width_of(WAYS);

    // Heap-ordered nodes: node n has lower child 2n+1 and upper child 2n+2.
    always_comb begin
        logic [WW-1:0] n;
        logic          b;
        plru_next = plru_bits;
        n = '0;
        for (int l = 0; l < WW; l++) begin
            b = access_way[WW-1-l];
            plru_next[n] = ~b;
            n = WW'(2 * int'(n) + 1 + int'(b));
        end
    end

    always_comb begin
        logic [WW-1:0] n;
        logic          b;
        victim_way = '0;
        n = '0;
        for (int l = 0; l < WW; l++) begin
            b = plru_bits[n];
            victim_way[WW-1-l] = b;
            n = WW'(2 * int'(n) + 1 + int'(b));
        end
    end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with zero-latency hits,
// invalid-first / tree-PLRU fill and a single-cycle invalidate-all flush.
module icache_nway
    import lc3b_types::*;
#(
    parameter int WAYS      = 4,
    parameter int SETS      = 8,
    parameter int LINE_BITS = LC3B_LINE_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 icache_read,
    input  logic [15:0]          icache_address,
    output lc3b_word             icache_rdata,
    output logic                 icache_resp,
    input  logic                 icache_flush,
    output logic                 icache_flush_done,
    input  logic                 L2_resp,
    input  logic [LINE_BITS-1:0] L2_rdata,
    output logic                 L2_read,
    output logic [15:0]          L2_address
);

    localparam int OFF = width_of(LINE_BITS / 8);
    localparam int IDX = width_of(SETS);
    localparam int TAG = 16 - OFF - IDX;
    localparam int WW  = width_of(WAYS);

    typedef logic [LINE_BITS-1:0] line_t;
    typedef logic [TAG-1:0]       tag_t;

    icache_state_e   state;
    logic            pending_flush;
    logic [SETS-1:0] valid [WAYS];
    logic [WAYS-2:0] plru  [SETS];
    tag_t            tag_arr  [WAYS][SETS];
    line_t           data_arr [WAYS][SETS];

    tag_t            req_tag;
    logic [IDX-1:0]  req_idx;
    logic [OFF-2:0]  word_sel;
    tag_t            fill_tag;
    logic [IDX-1:0]  fill_idx;
    logic [IDX-1:0]  set_idx;
    logic            unused_addr_bit;

    assign req_tag         = icache_address[15 -: TAG];
    assign req_idx         = icache_address[OFF +: IDX];
    assign word_sel        = icache_address[OFF-1:1];
    assign unused_addr_bit = icache_address[0];

    // The fill is steered by the latched L2 address so a requester that
    // drops or changes its address mid-fetch cannot corrupt the fill.
    assign fill_tag = L2_address[15 -: TAG];
    assign fill_idx = L2_address[OFF +: IDX];
    assign set_idx  = (state == ST_FETCH) ? fill_idx : req_idx;

    logic [WAYS-1:0] hit_vec;
    logic [WAYS-1:0] set_valid;
    logic            hit;
    logic [WW-1:0]   hit_way;
    logic [WW-1:0]   inv_way;
    logic [WW-1:0]   plru_victim;
    logic [WW-1:0]   fill_way;
    logic [WW-1:0]   access_way;
    logic [WAYS-2:0] plru_next;
    line_t           hit_line;

    always_comb begin
        hit_vec  = '0;
        hit_way  = '0;
        hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_valid[w] = valid[w][set_idx];
            hit_vec[w]   = valid[w][set_idx] && (tag_arr[w][set_idx] == req_tag);
            if (hit_vec[w]) begin
                hit_way  = WW'(w);
                hit_line = hit_line | data_arr[w][set_idx];
            end
        end
        hit = |hit_vec;
    end

    always_comb begin
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!set_valid[w]) inv_way = WW'(w);
        end
        fill_way = (&set_valid) ? plru_victim : inv_way;
    end

    assign access_way = (state == ST_FETCH) ? fill_way : hit_way;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .plru_bits  (plru[set_idx]),
        .access_way (access_way),
        .plru_next  (plru_next),
        .victim_way (plru_victim)
    );

    // A same-cycle flush request masks the hit response.
    assign icache_resp  = (state == ST_IDLE) && icache_read && hit && !icache_flush;
    assign icache_rdata = hit_line[{word_sel, 4'b0000} +: 16];

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            pending_flush     <= 1'b0;
            L2_read           <= 1'b0;
            icache_flush_done <= 1'b0;
            for (int w = 0; w < WAYS; w++) valid[w] <= '0;
            for (int s = 0; s < SETS; s++) plru[s] <= '0;
        end else begin
            icache_flush_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (icache_flush) begin
                        state             <= ST_FLUSH;
                        icache_flush_done <= 1'b1;
                    end else if (icache_read) begin
                        if (hit) begin
                            plru[set_idx] <= plru_next;
                        end else begin
                            state      <= ST_FETCH;
                            L2_read    <= 1'b1;
                            L2_address <= {req_tag, req_idx, {OFF{1'b0}}};
                        end
                    end
                end
                ST_FETCH: begin
                    if (L2_resp) begin
                        valid[fill_way][set_idx] <= 1'b1;
                        plru[set_idx]            <= plru_next;
                        L2_read                  <= 1'b0;
                        if (pending_flush || icache_flush) begin
                            state             <= ST_FLUSH;
                            icache_flush_done <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (icache_flush) begin
                        pending_flush <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    for (int w = 0; w < WAYS; w++) valid[w] <= '0;
                    for (int s = 0; s < SETS; s++) plru[s] <= '0;
                    pending_flush <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && (state == ST_FETCH) && L2_resp) begin
            tag_arr[fill_way][set_idx]  <= fill_tag;
            data_arr[fill_way][set_idx] <= L2_rdata;
        end
    end

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway at default parameters (4 ways, 8 sets,
// 128-bit lines): hits, fills, PLRU eviction, flush and reset cases.
module tb_icache_nway;

    logic         clk = 1'b0;
    logic         reset;
    logic         icache_read;
    logic [15:0]  icache_address;
    logic [15:0]  icache_rdata;
    logic         icache_resp;
    logic         icache_flush;
    logic         icache_flush_done;
    logic         L2_resp;
    logic [127:0] L2_rdata;
    logic         L2_read;
    logic [15:0]  L2_address;

    int n_tests = 0;
    int n_fail  = 0;

    icache_nway dut (
        .clk               (clk),
        .reset             (reset),
        .icache_read       (icache_read),
        .icache_address    (icache_address),
        .icache_rdata      (icache_rdata),
        .icache_resp       (icache_resp),
        .icache_flush      (icache_flush),
        .icache_flush_done (icache_flush_done),
        .L2_resp           (L2_resp),
        .L2_rdata          (L2_rdata),
        .L2_read           (L2_read),
        .L2_address        (L2_address)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mk_line(input logic [15:0] base);
        logic [127:0] l;
        for (int i = 0; i < 8; i++) l[16*i +: 16] = base + 16'(i);
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for L2_read, then returns one line after a short latency.
    task automatic fill(input logic [15:0] base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (L2_read) ok = 1'b1;
            else step();
        end
        if (ok) begin
            step();
            L2_rdata = mk_line(base);
            L2_resp  = 1'b1;
            step();
            L2_resp  = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; icache_read = 1'b0; icache_address = '0;
        icache_flush = 1'b0; L2_resp = 1'b0; L2_rdata = '0;
        step(); step();
        reset = 1'b0;
        #2;
        n_tests++;
        if ({icache_resp, L2_read, icache_flush_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: got resp/l2rd/done=%b required 000",
                     {icache_resp, L2_read, icache_flush_done});
        end
    endtask

    task automatic test_cold_miss();
        bit ok;
        step();
        icache_read = 1'b1; icache_address = 16'h1234;
        #2;
        n_tests++;
        if (icache_resp !== 1'b0) begin
            n_fail++; $display("FAIL cold_miss_resp: got %b required 0", icache_resp);
        end
        step();
        n_tests++;
        if (L2_read !== 1'b1 || L2_address !== 16'h1230) begin
            n_fail++;
            $display("FAIL cold_miss_l2req: got rd=%b addr=%h required rd=1 addr=1230",
                     L2_read, L2_address);
        end
        fill(16'hA000, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL cold_fill_timeout: got no L2_read required L2_read"); end
        #2;
        n_tests++;
        if (icache_resp !== 1'b1 || icache_rdata !== 16'hA002) begin
            n_fail++;
            $display("FAIL cold_hit: got resp=%b data=%h required resp=1 data=a002",
                     icache_resp, icache_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [4];
        logic [15:0] exp   [4];
        addrs = '{16'h1236, 16'h123E, 16'h1230, 16'h1238};
        exp   = '{16'hA003, 16'hA007, 16'hA000, 16'hA004};
        for (int i = 0; i < 4; i++) begin
            step();
            icache_address = addrs[i];
            #2;
            n_tests++;
            if (icache_resp !== 1'b1 || icache_rdata !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b_hit_%0d: got resp=%b data=%h required resp=1 data=%h",
                         i, icache_resp, icache_rdata, exp[i]);
            end
        end
    endtask

    // Misses the given address, fills with base, then checks the hit word 0.
    task automatic miss_fill_hit(input logic [15:0] a, input logic [15:0] base,
                                 input string name);
        bit ok;
        step();
        icache_read = 1'b1; icache_address = a;
        #2;
        n_tests++;
        if (icache_resp !== 1'b0) begin
            n_fail++; $display("FAIL %s_miss: got resp=%b required 0", name, icache_resp);
        end
        step();
        n_tests++;
        if (L2_read !== 1'b1 || L2_address !== a) begin
            n_fail++;
            $display("FAIL %s_l2req: got rd=%b addr=%h required rd=1 addr=%h",
                     name, L2_read, L2_address, a);
        end
        fill(base, ok);
        #2;
        n_tests++;
        if (!ok || icache_resp !== 1'b1 || icache_rdata !== base) begin
            n_fail++;
            $display("FAIL %s_fillhit: got ok=%b resp=%b data=%h required ok=1 resp=1 data=%h",
                     name, ok, icache_resp, icache_rdata, base);
        end
    endtask

    task automatic test_invalid_first();
        miss_fill_hit(16'h0000, 16'hB000, "fill0");
        miss_fill_hit(16'h0080, 16'hB100, "fill1");
        miss_fill_hit(16'h0100, 16'hB200, "fill2");
        miss_fill_hit(16'h0180, 16'hB300, "fill3");
        for (int i = 0; i < 4; i++) begin
            logic [15:0] a;
            logic [15:0] e;
            a = 16'(i * 16'h0080) + 16'h0002;
            e = 16'hB000 + 16'(i * 16'h0100) + 16'h0001;
            step();
            icache_address = a;
            #2;
            n_tests++;
            if (icache_resp !== 1'b1 || icache_rdata !== e) begin
                n_fail++;
                $display("FAIL set0_hit_%0d: got resp=%b data=%h required resp=1 data=%h",
                         i, icache_resp, icache_rdata, e);
            end
        end
    endtask

    task automatic test_plru_evict();
        step();
        icache_address = 16'h0000;
        #2;
        n_tests++;
        if (icache_resp !== 1'b1 || icache_rdata !== 16'hB000) begin
            n_fail++;
            $display("FAIL plru_pre_hit: got resp=%b data=%h required resp=1 data=b000",
                     icache_resp, icache_rdata);
        end
        miss_fill_hit(16'h0200, 16'hC000, "evict");
        step();
        icache_address = 16'h0000;
        #2;
        n_tests++;
        if (icache_resp !== 1'b1 || icache_rdata !== 16'hB000) begin
            n_fail++;
            $display("FAIL plru_keep_0000: got resp=%b data=%h required resp=1 data=b000",
                     icache_resp, icache_rdata);
        end
        step();
        icache_address = 16'h0180;
        #2;
        n_tests++;
        if (icache_resp !== 1'b1 || icache_rdata !== 16'hB300) begin
            n_fail++;
            $display("FAIL plru_keep_0180: got resp=%b data=%h required resp=1 data=b300",
                     icache_resp, icache_rdata);
        end
        // 0x0100 was evicted; refilling it now displaces 0x0080 (way 1).
        miss_fill_hit(16'h0100, 16'hB200, "refill0100");
        step();
        icache_address = 16'h0200;
        #2;
        n_tests++;
        if (icache_resp !== 1'b1 || icache_rdata !== 16'hC000) begin
            n_fail++;
            $display("FAIL plru_keep_0200: got resp=%b data=%h required resp=1 data=c000",
                     icache_resp, icache_rdata);
        end
    endtask

    task automatic test_read_drop();
        bit ok;
        step();
        icache_read = 1'b1; icache_address = 16'h0300;
        step();
        icache_read = 1'b0;
        fill(16'hD000, ok);
        #2;
        n_tests++;
        if (!ok || icache_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_noresp: got ok=%b resp=%b required ok=1 resp=0", ok, icache_resp);
        end
        icache_read = 1'b1; icache_address = 16'h0304;
        #1;
        n_tests++;
        if (icache_resp !== 1'b1 || icache_rdata !== 16'hD002) begin
            n_fail++;
            $display("FAIL drop_filled: got resp=%b data=%h required resp=1 data=d002",
                     icache_resp, icache_rdata);
        end
    endtask

    task automatic test_flush_idle();
        bit ok;
        step();
        icache_read = 1'b1; icache_address = 16'h0000; icache_flush = 1'b1;
        #2;
        n_tests++;
        if (icache_resp !== 1'b0 || icache_flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_suppress: got resp=%b done=%b required 0 0",
                     icache_resp, icache_flush_done);
        end
        step();
        icache_flush = 1'b0;
        n_tests++;
        if (icache_flush_done !== 1'b1 || icache_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_done: got done=%b resp=%b required 1 0",
                     icache_flush_done, icache_resp);
        end
        step();
        #2;
        n_tests++;
        if (icache_flush_done !== 1'b0 || icache_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_after: got done=%b resp=%b required 0 0",
                     icache_flush_done, icache_resp);
        end
        step();
        n_tests++;
        if (L2_read !== 1'b1 || L2_address !== 16'h0000) begin
            n_fail++;
            $display("FAIL flush_idle_refetch: got rd=%b addr=%h required rd=1 addr=0000",
                     L2_read, L2_address);
        end
        fill(16'hB000, ok);
        #2;
        n_tests++;
        if (!ok || icache_resp !== 1'b1 || icache_rdata !== 16'hB000) begin
            n_fail++;
            $display("FAIL flush_idle_refill: got ok=%b resp=%b data=%h required 1 1 b000",
                     ok, icache_resp, icache_rdata);
        end
    endtask

    task automatic test_flush_fetch();
        step();
        icache_address = 16'h0400;
        step();
        icache_flush = 1'b1;
        step();
        icache_flush = 1'b0;
        n_tests++;
        if (L2_read !== 1'b1 || icache_flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_fetch_hold: got rd=%b done=%b required 1 0",
                     L2_read, icache_flush_done);
        end
        L2_rdata = mk_line(16'hE000);
        L2_resp  = 1'b1;
        step();
        L2_resp  = 1'b0;
        n_tests++;
        if (icache_flush_done !== 1'b1 || icache_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_fetch_done: got done=%b resp=%b required 1 0",
                     icache_flush_done, icache_resp);
        end
        step();
        #2;
        n_tests++;
        if (icache_resp !== 1'b0 || icache_flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_fetch_invalid: got resp=%b done=%b required 0 0",
                     icache_resp, icache_flush_done);
        end
        step();
        n_tests++;
        if (L2_read !== 1'b1 || L2_address !== 16'h0400) begin
            n_fail++;
            $display("FAIL flush_fetch_refetch: got rd=%b addr=%h required rd=1 addr=0400",
                     L2_read, L2_address);
        end
    endtask

    // Entered while the previous test left the cache in FETCH for 0x0400.
    task automatic test_reset_mid_fetch();
        bit ok;
        reset   = 1'b1;
        L2_rdata = mk_line(16'hF000);
        L2_resp = 1'b1;
        step();
        reset = 1'b0; L2_resp = 1'b0; icache_read = 1'b0;
        n_tests++;
        if ({L2_read, icache_resp, icache_flush_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_fetch_out: got rd/resp/done=%b required 000",
                     {L2_read, icache_resp, icache_flush_done});
        end
        icache_read = 1'b1; icache_address = 16'h0400;
        #2;
        n_tests++;
        if (icache_resp !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_fetch_nofill: got resp=%b required 0", icache_resp);
        end
        icache_address = 16'h1234;
        #1;
        n_tests++;
        if (icache_resp !== 1'b0) begin
            n_fail++; $display("FAIL reset_invalidates: got resp=%b required 0", icache_resp);
        end
        step();
        n_tests++;
        if (L2_read !== 1'b1 || L2_address !== 16'h1230) begin
            n_fail++;
            $display("FAIL reset_refetch: got rd=%b addr=%h required rd=1 addr=1230",
                     L2_read, L2_address);
        end
        fill(16'hA000, ok);
        #2;
        n_tests++;
        if (!ok || icache_resp !== 1'b1 || icache_rdata !== 16'hA002) begin
            n_fail++;
            $display("FAIL reset_refill: got ok=%b resp=%b data=%h required 1 1 a002",
                     ok, icache_resp, icache_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_invalid_first();
        test_plru_evict();
        test_read_drop();
        test_flush_idle();
        test_flush_fetch();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
